// File: rtl/decoder_n_buffered_if.sv
// -----------------------------------------------------------------------------
// decoder_n_buffered_if
//   Bundles the three handshake channels of decoder_n_buffered:
//     in_data/in_valid/in_ready     data token channel
//     s_data/s_valid/s_ready        destination select channel
//     out_data/out_valid/out_ready  NOUT output channels, slice k = [k*W +: W]
//   Modports:
//     master - the producer/consumer environment around the decoder
//     slave  - the decoder itself
//   Parameters: W (data width), NOUT (output count), SW (select width,
//   max(1, clog2(NOUT))).
// -----------------------------------------------------------------------------
interface decoder_n_buffered_if #(
  parameter int W    = 9,
  parameter int NOUT = 2,
  parameter int SW   = (NOUT > 2) ? $clog2(NOUT) : 1
) ();
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [NOUT*W-1:0] out_data;
  logic [NOUT-1:0]   out_valid;
  logic [NOUT-1:0]   out_ready;

  modport master (
    output in_data, in_valid, s_data, s_valid, out_ready,
    input  in_ready, s_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, s_data, s_valid, out_ready,
    output in_ready, s_ready, out_data, out_valid
  );
endinterface

// File: rtl/decoder_n_buffered.sv
// -----------------------------------------------------------------------------
// decoder_n_buffered
//   Routes each data token to the output named by the matching select token.
//   Every output owns a DEPTH-entry FIFO, so a stalled output never blocks
//   traffic to the others. Select values >= NOUT consume and discard the token.
//
//   Ports:
//     CLK       rising-edge clock
//     _RESET    asynchronous active-low reset
//     bus       decoder_n_buffered_if.slave (data, select and output channels)
//     err       (optional) sticky flag, set by any dropped token
//     drop_cnt  (optional) saturating count of dropped tokens
//
//   Optional feature: define DECODER_N_BUFFERED_ERR_EN to add err/drop_cnt.
// -----------------------------------------------------------------------------
module decoder_n_buffered #(
  parameter int W     = 9,
  parameter int NOUT  = 2,
  parameter int DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  decoder_n_buffered_if.slave  bus
`ifdef DECODER_N_BUFFERED_ERR_EN
  ,
  output logic                 err,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int SW = (NOUT > 2) ? $clog2(NOUT) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem    [NOUT][DEPTH];
  logic [PW-1:0] rd_ptr [NOUT];
  logic [PW-1:0] wr_ptr [NOUT];
  logic [CW-1:0] cnt    [NOUT];

  logic [SW-1:0]   sel;
  logic            in_range;
  logic            sel_full;
  logic            xfer;
  logic [NOUT-1:0] push;
  logic [NOUT-1:0] pop;

  assign sel = bus.s_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Acceptance looks only at the registered fill level, never at out_ready,
  // so a full FIFO stays closed even in the cycle it pops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_range = 1'b0;
    sel_full = 1'b0;
    push     = '0;
    pop      = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (int'(sel) == k) begin
        in_range = 1'b1;
        sel_full = (cnt[k] == CW'(DEPTH));
      end
    end
    xfer = _RESET && bus.in_valid && bus.s_valid && !(in_range && sel_full);
    for (int k = 0; k < NOUT; k++) begin
      push[k] = xfer && (int'(sel) == k);
      pop[k]  = (cnt[k] != '0) && bus.out_ready[k];
    end
  end

  assign bus.in_ready = xfer;
  assign bus.s_ready  = xfer;

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int k = 0; k < NOUT; k++) begin
      bus.out_valid[k]       = (cnt[k] != '0);
      bus.out_data[k*W +: W] = mem[k][rd_ptr[k]];
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      for (int k = 0; k < NOUT; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        cnt[k]    <= '0;
        // NOTE: storage is reset because out_data is read straight from it and must be 0 in reset.
        for (int d = 0; d < DEPTH; d++) mem[k][d] <= '0;
      end
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        // NOTE: state uses non-blocking assignments so every FIFO sees pre-edge values.
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= bus.in_data;
          wr_ptr[k]         <= ptr_inc(wr_ptr[k]);
        end
        if (pop[k]) rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

`ifdef DECODER_N_BUFFERED_ERR_EN
  logic drop;
  assign drop = xfer && !in_range;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_n_buffered.sv
// -----------------------------------------------------------------------------
// tb_decoder_n_buffered
//   Two decoders share clock and reset:
//     inst 0 (bus_a): NOUT=2, DEPTH=2
//     inst 1 (bus_b): NOUT=3, DEPTH=1 (has an out-of-range select value 3)
//   A reference model keeps one queue of expected tokens per output; a monitor
//   thread compares every output and handshake against it at each falling edge.
// -----------------------------------------------------------------------------
module tb_decoder_n_buffered;

  logic CLK = 1'b0;
  logic _RESET;
  int   n_vec = 0;
  int   n_bad = 0;

  decoder_n_buffered_if #(.W(9), .NOUT(2)) bus_a ();
  decoder_n_buffered_if #(.W(9), .NOUT(3)) bus_b ();

`ifdef DECODER_N_BUFFERED_ERR_EN
  logic       err_a, err_b;
  logic [7:0] dc_a, dc_b;
`endif

  decoder_n_buffered #(.W(9), .NOUT(2), .DEPTH(2)) dut_a (
    .CLK      (CLK),
    ._RESET   (_RESET),
    .bus      (bus_a)
`ifdef DECODER_N_BUFFERED_ERR_EN
    ,
    .err      (err_a),
    .drop_cnt (dc_a)
`endif
  );

  decoder_n_buffered #(.W(9), .NOUT(3), .DEPTH(1)) dut_b (
    .CLK      (CLK),
    ._RESET   (_RESET),
    .bus      (bus_b)
`ifdef DECODER_N_BUFFERED_ERR_EN
    ,
    .err      (err_b),
    .drop_cnt (dc_b)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: expected tokens per instance and output, and drop totals.
  logic [8:0] mq [2][3][$];
  int         drops [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      drops[i] = 0;
      for (int k = 0; k < 3; k++) mq[i][k].delete();
    end
  endtask

  task automatic set_in(input int inst, input logic iv, input logic [8:0] d,
                        input logic sv, input int s);
    if (inst == 0) begin
      bus_a.in_valid = iv; bus_a.in_data = d; bus_a.s_valid = sv; bus_a.s_data = 1'(s);
    end else begin
      bus_b.in_valid = iv; bus_b.in_data = d; bus_b.s_valid = sv; bus_b.s_data = 2'(s);
    end
  endtask

  task automatic set_ready(input int inst, input logic [2:0] r);
    if (inst == 0) bus_a.out_ready = r[1:0];
    else           bus_b.out_ready = r;
  endtask

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  // Compares one instance against the model, then advances the model by the
  // handshakes that complete at the coming rising edge.
  task automatic score(input int inst, input int nout, input int depth, input logic rst,
                       input logic iv, input logic sv, input logic ir, input logic sr,
                       input int s, input logic [8:0] d, input logic [2:0] ov,
                       input logic [2:0] orr, input logic [26:0] od,
                       input logic e, input logic [7:0] dc);
    logic exp_r;
    if (!rst) begin
      check("rst_out_valid", 32'(ov), 32'd0);
      check("rst_out_data", 32'(od), 32'd0);
      check("rst_in_ready", 32'(ir), 32'd0);
      check("rst_s_ready", 32'(sr), 32'd0);
      drops[inst] = 0;
      for (int k = 0; k < 3; k++) mq[inst][k].delete();
      return;
    end
    exp_r = 1'b0;
    if (iv && sv) begin
      if (s >= nout) exp_r = 1'b1;
      else           exp_r = (mq[inst][s].size() < depth);
    end
    for (int k = 0; k < nout; k++) begin
      check($sformatf("out_valid%0d_i%0d", k, inst), 32'(ov[k]), 32'(mq[inst][k].size() != 0));
      if (ov[k] && mq[inst][k].size() != 0)
        check($sformatf("out_data%0d_i%0d", k, inst), 32'(od[k*9 +: 9]), 32'(mq[inst][k][0]));
    end
    check($sformatf("in_ready_i%0d", inst), 32'(ir), 32'(exp_r));
    check($sformatf("s_ready_i%0d", inst), 32'(sr), 32'(exp_r));
`ifdef DECODER_N_BUFFERED_ERR_EN
    check($sformatf("err_i%0d", inst), 32'(e), 32'(drops[inst] > 0));
    check($sformatf("drop_cnt_i%0d", inst), 32'(dc), 32'((drops[inst] > 255) ? 255 : drops[inst]));
`endif
    for (int k = 0; k < nout; k++)
      if (ov[k] && orr[k] && mq[inst][k].size() != 0) void'(mq[inst][k].pop_front());
    if (ir && iv && sv) begin
      if (s < nout) mq[inst][s].push_back(d);
      else          drops[inst]++;
    end
  endtask

  task automatic monitor();
    logic       ea, eb;
    logic [7:0] da, db;
    forever begin
      @(negedge CLK);
`ifdef DECODER_N_BUFFERED_ERR_EN
      ea = err_a; eb = err_b; da = dc_a; db = dc_b;
`else
      ea = 1'b0; eb = 1'b0; da = '0; db = '0;
`endif
      score(0, 2, 2, _RESET, bus_a.in_valid, bus_a.s_valid, bus_a.in_ready, bus_a.s_ready,
            int'(bus_a.s_data), bus_a.in_data, {1'b0, bus_a.out_valid},
            {1'b0, bus_a.out_ready}, {9'b0, bus_a.out_data}, ea, da);
      score(1, 3, 1, _RESET, bus_b.in_valid, bus_b.s_valid, bus_b.in_ready, bus_b.s_ready,
            int'(bus_b.s_data), bus_b.in_data, bus_b.out_valid,
            bus_b.out_ready, bus_b.out_data, eb, db);
    end
  endtask

  // Offers one token from posedge+1 until accepted; returns stalled cycles.
  task automatic send(input int inst, input logic [8:0] d, input int s, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    set_in(inst, 1'b1, d, 1'b1, s);
    while (!acc && waited < 50) begin
      @(negedge CLK);
      acc = get_ready(inst);
      @(posedge CLK);
      #1;
      if (!acc) waited++;
    end
    set_in(inst, 1'b0, 9'h0, 1'b0, 0);
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    int w;
    int acc_cnt;
    logic took;

    _RESET = 1'b0;
    set_in(0, 1'b0, 9'h0, 1'b0, 0);
    set_in(1, 1'b0, 9'h0, 1'b0, 0);
    set_ready(0, 3'b000);
    set_ready(1, 3'b000);
    clear_model();
    fork
      monitor();
    join_none

    // Reset state with traffic offered: outputs quiet, ready held low.
    repeat (2) @(negedge CLK);
    set_in(0, 1'b1, 9'h1FF, 1'b1, 0);
    @(negedge CLK);
    check("reset_ready_low", 32'(bus_a.in_ready), 32'd0);
    set_in(0, 1'b0, 9'h0, 1'b0, 0);
    @(posedge CLK);
    #1 _RESET = 1'b1;

    // Basic routing; the first token lands on the first edge after release.
    set_ready(0, 3'b011);
    send(0, 9'h1A5, 1, w);
    check("first_edge_xfer", 32'(w), 32'd0);
    check("out1_valid", 32'(bus_a.out_valid), 32'b10);
    check("out1_data", 32'(bus_a.out_data[17:9]), 32'h1A5);
    send(0, 9'h0F0, 0, w);
    check("out0_valid", 32'(bus_a.out_valid), 32'b01);
    check("out0_data", 32'(bus_a.out_data[8:0]), 32'h0F0);
    @(posedge CLK); #1;

    // Stall output 0: two tokens fit, the third waits for a pop.
    set_ready(0, 3'b010);
    send(0, 9'h011, 0, w);
    send(0, 9'h022, 0, w);
    set_in(0, 1'b1, 9'h033, 1'b1, 0);
    @(negedge CLK);
    check("full_stall", 32'(bus_a.in_ready), 32'd0);
    @(posedge CLK); #1;
    set_ready(0, 3'b011);
    @(negedge CLK);
    check("ready_not_comb", 32'(bus_a.in_ready), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("accept_after_pop", 32'(bus_a.in_ready), 32'd1);
    @(posedge CLK); #1;
    set_in(0, 1'b0, 9'h0, 1'b0, 0);
    repeat (4) @(posedge CLK);
    #1;

    // Output 0 full and stalled must not block output 1.
    set_ready(0, 3'b010);
    send(0, 9'h044, 0, w);
    send(0, 9'h055, 0, w);
    send(0, 9'h133, 1, w);
    check("bypass_stalled", 32'(w), 32'd0);
    check("bypass_valid", 32'(bus_a.out_valid[1]), 32'd1);
    check("bypass_data", 32'(bus_a.out_data[17:9]), 32'h133);

    // Fill both FIFOs, then reset between clock edges.
    set_ready(0, 3'b000);
    send(0, 9'h0AA, 1, w);
    check("both_full", 32'(bus_a.out_valid), 32'b11);
    @(posedge CLK);
    #3 _RESET = 1'b0;
    #1;
    check("async_clear_valid", 32'(bus_a.out_valid), 32'd0);
    check("async_clear_data", 32'(bus_a.out_data), 32'd0);
    clear_model();
    @(posedge CLK);
    #1 _RESET = 1'b1;
    set_ready(0, 3'b011);
    repeat (3) begin
      @(negedge CLK);
      check("no_stale", 32'(bus_a.out_valid), 32'd0);
    end
    @(posedge CLK); #1;

    // Out-of-range select on the NOUT=3 instance.
    set_ready(1, 3'b111);
    send(1, 9'h155, 3, w);
    check("drop_no_stall", 32'(w), 32'd0);
    check("drop_no_valid", 32'(bus_b.out_valid), 32'd0);
`ifdef DECODER_N_BUFFERED_ERR_EN
    check("drop_err", 32'(err_b), 32'd1);
    check("drop_cnt_one", 32'(dc_b), 32'd1);
`endif
    repeat (299) send(1, 9'($urandom), 3, w);
`ifdef DECODER_N_BUFFERED_ERR_EN
    check("drop_cnt_sat", 32'(dc_b), 32'd255);
    check("drop_err_sticky", 32'(err_b), 32'd1);
`endif

    // DEPTH=1 streaming: one acceptance every two cycles.
    acc_cnt = 0;
    set_in(1, 1'b1, 9'($urandom), 1'b1, 0);
    repeat (40) begin
      @(negedge CLK);
      took = bus_b.in_ready;
      if (took) acc_cnt++;
      @(posedge CLK); #1;
      if (took) set_in(1, 1'b1, 9'($urandom), 1'b1, 0);
    end
    set_in(1, 1'b0, 9'h0, 1'b0, 0);
    check("depth1_rate", 32'(acc_cnt), 32'd20);

    // Random traffic on both instances.
    repeat (600) begin
      set_in(0, 1'($urandom), 9'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
      set_in(1, 1'($urandom), 9'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      set_ready(0, 3'($urandom));
      set_ready(1, 3'($urandom));
      @(posedge CLK); #1;
    end

    // Drain.
    set_in(0, 1'b0, 9'h0, 1'b0, 0);
    set_in(1, 1'b0, 9'h0, 1'b0, 0);
    set_ready(0, 3'b111);
    set_ready(1, 3'b111);
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("drain_a", 32'(bus_a.out_valid), 32'd0);
    check("drain_b", 32'(bus_b.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
